// File: rtl/pe_sched.sv
// pe_sched: tile scheduler that steps the PE engine through one convolution layer.
// Loop order, from outermost: output-channel tile, input-channel tile, row, column.
// Each input-channel tile starts with a filter-sync handshake. Pixels are then
// streamed one per accepted i_ifm_rdy cycle. After the last pixel of the layer
// the scheduler waits for the PE pipeline to drain, then pulses o_done.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   i_start                  layer start pulse; ignored while a layer is running
//   q_width/q_height         tile columns/rows, latched at an accepted start
//   q_channel/q_channel_out  input/output channel tile counts, latched at start
//   i_ifm_rdy                IFM buffer accepts a pixel read this cycle
//   i_pe_csync_done          PE engine filter load complete
//   o_ctrl_csync_run         filter-sync phase active
//   o_ctrl_data_run          pixel valid this cycle
//   o_row/o_col/o_chn/o_chn_out and o_is_*  coordinate and position flags
//   o_busy, o_done           layer in progress, one-cycle completion pulse
// Optional: define PE_SCHED_PERF_CNT_EN to add the o_cycle_cnt and o_stall_cnt
// performance counters.
module pe_sched #(
  parameter int unsigned W_SIZE    = 9,
  parameter int unsigned W_CHANNEL = 9,
  parameter int unsigned DRAIN     = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic [W_SIZE-1:0]    q_width,
  input  logic [W_SIZE-1:0]    q_height,
  input  logic [W_CHANNEL-1:0] q_channel,
  input  logic [W_CHANNEL-1:0] q_channel_out,
  input  logic                 i_ifm_rdy,
  input  logic                 i_pe_csync_done,
  output logic                 o_ctrl_csync_run,
  output logic                 o_ctrl_data_run,
  output logic [W_SIZE-1:0]    o_row,
  output logic [W_SIZE-1:0]    o_col,
  output logic [W_CHANNEL-1:0] o_chn,
  output logic [W_CHANNEL-1:0] o_chn_out,
  output logic                 o_is_first_row,
  output logic                 o_is_last_row,
  output logic                 o_is_first_col,
  output logic                 o_is_last_col,
  output logic                 o_is_first_chn,
  output logic                 o_is_last_chn,
`ifdef PE_SCHED_PERF_CNT_EN
  output logic [31:0]          o_cycle_cnt,
  output logic [31:0]          o_stall_cnt,
`endif
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int unsigned WDrain = $clog2(DRAIN + 1);

  typedef enum logic [2:0] {StIdle, StCsync, StData, StDrain, StSkip, StDone} state_e;

  state_e               state_q;
  logic [W_SIZE-1:0]    w_q, h_q, row_q, col_q;
  logic [W_CHANNEL-1:0] nch_q, ncho_q, chn_q, cho_q;
  logic [WDrain-1:0]    drain_cnt_q;
  logic                 col_end, row_end, chn_end, cho_end;

  // Flag order: first_row, last_row, first_col, last_col, first_chn, last_chn.
  function automatic logic [5:0] pos_flags(input logic [W_SIZE-1:0]    r,
                                           input logic [W_SIZE-1:0]    c,
                                           input logic [W_SIZE-1:0]    h,
                                           input logic [W_SIZE-1:0]    w,
                                           input logic [W_CHANNEL-1:0] ch,
                                           input logic [W_CHANNEL-1:0] nch);
    return {r == '0, r == h - W_SIZE'(1), c == '0, c == w - W_SIZE'(1),
            ch == '0, ch == nch - W_CHANNEL'(1)};
  endfunction

  always_comb begin
    col_end = (col_q == w_q - W_SIZE'(1));
    row_end = (row_q == h_q - W_SIZE'(1));
    chn_end = (chn_q == nch_q - W_CHANNEL'(1));
    cho_end = (cho_q == ncho_q - W_CHANNEL'(1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= StIdle;
      w_q              <= '0;
      h_q              <= '0;
      nch_q            <= '0;
      ncho_q           <= '0;
      row_q            <= '0;
      col_q            <= '0;
      chn_q            <= '0;
      cho_q            <= '0;
      drain_cnt_q      <= '0;
      o_ctrl_csync_run <= 1'b0;
      o_ctrl_data_run  <= 1'b0;
      o_row            <= '0;
      o_col            <= '0;
      o_chn            <= '0;
      o_chn_out        <= '0;
      {o_is_first_row, o_is_last_row, o_is_first_col, o_is_last_col,
       o_is_first_chn, o_is_last_chn} <= '0;
      o_busy           <= 1'b0;
      o_done           <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (i_start) begin
            w_q    <= q_width;
            h_q    <= q_height;
            nch_q  <= q_channel;
            ncho_q <= q_channel_out;
            row_q  <= '0;
            col_q  <= '0;
            chn_q  <= '0;
            cho_q  <= '0;
            if (q_width == '0 || q_height == '0 || q_channel == '0 || q_channel_out == '0) begin
              state_q <= StSkip;
            end else begin
              // Sync starts on this edge, so flags come from the raw inputs.
              state_q          <= StCsync;
              o_busy           <= 1'b1;
              o_ctrl_csync_run <= 1'b1;
              o_row            <= '0;
              o_col            <= '0;
              o_chn            <= '0;
              o_chn_out        <= '0;
              {o_is_first_row, o_is_last_row, o_is_first_col, o_is_last_col,
               o_is_first_chn, o_is_last_chn} <=
                pos_flags('0, '0, q_height, q_width, '0, q_channel);
            end
          end
        end
        StCsync: begin
          o_ctrl_data_run <= 1'b0;
          // Only a done seen while sync is visibly high counts; entry from DATA
          // spends one cycle with sync low so the engine sees a fresh rising edge.
          if (o_ctrl_csync_run && i_pe_csync_done) begin
            o_ctrl_csync_run <= 1'b0;
            state_q          <= StData;
          end else begin
            o_ctrl_csync_run <= 1'b1;
            o_row            <= row_q;
            o_col            <= col_q;
            o_chn            <= chn_q;
            o_chn_out        <= cho_q;
            {o_is_first_row, o_is_last_row, o_is_first_col, o_is_last_col,
             o_is_first_chn, o_is_last_chn} <= pos_flags(row_q, col_q, h_q, w_q, chn_q, nch_q);
          end
        end
        StData: begin
          if (i_ifm_rdy) begin
            o_ctrl_data_run <= 1'b1;
            o_row           <= row_q;
            o_col           <= col_q;
            o_chn           <= chn_q;
            o_chn_out       <= cho_q;
            {o_is_first_row, o_is_last_row, o_is_first_col, o_is_last_col,
             o_is_first_chn, o_is_last_chn} <= pos_flags(row_q, col_q, h_q, w_q, chn_q, nch_q);
            if (!col_end) begin
              col_q <= col_q + W_SIZE'(1);
            end else begin
              col_q <= '0;
              if (!row_end) begin
                row_q <= row_q + W_SIZE'(1);
              end else begin
                row_q <= '0;
                if (chn_end && cho_end) begin
                  state_q     <= StDrain;
                  drain_cnt_q <= '0;
                end else begin
                  state_q <= StCsync;
                  if (chn_end) begin
                    chn_q <= '0;
                    cho_q <= cho_q + W_CHANNEL'(1);
                  end else begin
                    chn_q <= chn_q + W_CHANNEL'(1);
                  end
                end
              end
            end
          end else begin
            o_ctrl_data_run <= 1'b0;
          end
        end
        StDrain: begin
          o_ctrl_data_run <= 1'b0;
          if (drain_cnt_q == WDrain'(DRAIN)) begin
            state_q <= StDone;
            o_busy  <= 1'b0;
            o_done  <= 1'b1;
          end else begin
            drain_cnt_q <= drain_cnt_q + WDrain'(1);
          end
        end
        StSkip: begin
          state_q <= StDone;
          o_done  <= 1'b1;
        end
        StDone: begin
          state_q <= StIdle;
          o_done  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef PE_SCHED_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_cycle_cnt <= '0;
      o_stall_cnt <= '0;
    end else if (state_q == StIdle && i_start) begin
      o_cycle_cnt <= '0;
      o_stall_cnt <= '0;
    end else begin
      if (o_busy && o_cycle_cnt != '1) o_cycle_cnt <= o_cycle_cnt + 32'd1;
      if (state_q == StData && !i_ifm_rdy && o_stall_cnt != '1) begin
        o_stall_cnt <= o_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pe_sched.sv
// Directed testbench for pe_sched: reset, basic layer, multi-tile ordering,
// stalls, zero-size layer, start while busy and reset mid-layer.
module tb_pe_sched;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_start = 1'b0;
  logic [8:0] q_width = '0, q_height = '0, q_channel = '0, q_channel_out = '0;
  logic       i_ifm_rdy = 1'b1;
  logic       i_pe_csync_done = 1'b0;
  logic       o_ctrl_csync_run, o_ctrl_data_run;
  logic [8:0] o_row, o_col, o_chn, o_chn_out;
  logic       o_is_first_row, o_is_last_row, o_is_first_col, o_is_last_col;
  logic       o_is_first_chn, o_is_last_chn, o_busy, o_done;
`ifdef PE_SCHED_PERF_CNT_EN
  logic [31:0] o_cycle_cnt, o_stall_cnt;
`endif

  pe_sched #(.W_SIZE(9), .W_CHANNEL(9), .DRAIN(15)) dut (
    .clk(clk), .rst(rst), .i_start(i_start),
    .q_width(q_width), .q_height(q_height), .q_channel(q_channel),
    .q_channel_out(q_channel_out), .i_ifm_rdy(i_ifm_rdy),
    .i_pe_csync_done(i_pe_csync_done),
    .o_ctrl_csync_run(o_ctrl_csync_run), .o_ctrl_data_run(o_ctrl_data_run),
    .o_row(o_row), .o_col(o_col), .o_chn(o_chn), .o_chn_out(o_chn_out),
    .o_is_first_row(o_is_first_row), .o_is_last_row(o_is_last_row),
    .o_is_first_col(o_is_first_col), .o_is_last_col(o_is_last_col),
    .o_is_first_chn(o_is_first_chn), .o_is_last_chn(o_is_last_chn),
`ifdef PE_SCHED_PERF_CNT_EN
    .o_cycle_cnt(o_cycle_cnt), .o_stall_cnt(o_stall_cnt),
`endif
    .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int start_cyc = 0;
  int rdy_mode = 0;  // 0: always ready, 1: toggle every cycle

  always @(posedge clk) cyc <= cyc + 1;

  // Event log filled by the monitor, examined by the test tasks.
  int         pix_n, done_n, done_cyc, sync_n, first_sync_cyc, busy_cnt;
  logic [8:0] pr[64], pc[64], pch[64], pco[64];
  logic [5:0] pf[64];
  int         pcyc[64];
  logic [8:0] sync_chn[8], sync_cho[8];
  int         sync_cyc[8];
  logic       sync_prev = 1'b0, overlap, busy_seen, busy_at_done;

  always @(negedge clk) begin
    if (o_ctrl_data_run && pix_n < 64) begin
      pr[pix_n]   = o_row;
      pc[pix_n]   = o_col;
      pch[pix_n]  = o_chn;
      pco[pix_n]  = o_chn_out;
      pf[pix_n]   = {o_is_first_row, o_is_last_row, o_is_first_col, o_is_last_col,
                     o_is_first_chn, o_is_last_chn};
      pcyc[pix_n] = cyc;
      pix_n++;
    end
    if (o_ctrl_csync_run && !sync_prev && sync_n < 8) begin
      sync_chn[sync_n] = o_chn;
      sync_cho[sync_n] = o_chn_out;
      sync_cyc[sync_n] = cyc;
      if (sync_n == 0) first_sync_cyc = cyc;
      sync_n++;
    end
    sync_prev = o_ctrl_csync_run;
    if (o_ctrl_csync_run && o_ctrl_data_run) overlap = 1'b1;
    if (o_busy) begin
      busy_seen = 1'b1;
      busy_cnt++;
    end
    if (o_done) begin
      done_n++;
      done_cyc = cyc;
      busy_at_done = o_busy;
    end
  end

  // PE engine answers sync 3 cycles after it sees o_ctrl_csync_run rise; IFM ready driver.
  int sync_cnt = 0;
`ifdef PE_SCHED_PERF_CNT_EN
  int sm_pix, sm_total, sm_stall;
  logic sm_synced;
`endif
  always @(negedge clk) begin
    if (rst) begin
      sync_cnt = 0;
      i_pe_csync_done = 1'b0;
    end else begin
      if (o_ctrl_csync_run) sync_cnt++;
      else sync_cnt = 0;
      i_pe_csync_done = (sync_cnt == 3);
    end
    if (rdy_mode == 0) i_ifm_rdy = 1'b1;
    else i_ifm_rdy = ~i_ifm_rdy;
`ifdef PE_SCHED_PERF_CNT_EN
    // Single-tile model of DATA-state cycles that end with i_ifm_rdy low.
    if (o_ctrl_csync_run) sm_synced = 1'b1;
    if (o_ctrl_data_run) sm_pix++;
    if (o_busy && !o_ctrl_csync_run && sm_synced && sm_pix < sm_total && !i_ifm_rdy) sm_stall++;
`endif
  end

  task automatic clear_log(input int total);
    pix_n = 0; done_n = 0; done_cyc = 0; sync_n = 0; first_sync_cyc = 0; busy_cnt = 0;
    overlap = 1'b0; busy_seen = 1'b0; busy_at_done = 1'b0;
`ifdef PE_SCHED_PERF_CNT_EN
    sm_pix = 0; sm_total = total; sm_stall = 0; sm_synced = 1'b0;
`else
    if (total < 0) $display("negative pixel total %0d", total);
`endif
  endtask

  task automatic start_layer(input int w, input int h, input int c, input int co);
    @(negedge clk);
    q_width = w[8:0]; q_height = h[8:0]; q_channel = c[8:0]; q_channel_out = co[8:0];
    i_start = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (done_n == 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    if (done_n == 0) begin
      n_vec++; n_err++;
      $display("FAIL done_timeout: no o_done within %0d cycles, required one", budget);
    end
  endtask

  function automatic logic [41:0] exp_pix(input int r, input int c, input int ch, input int co,
                                          input int h, input int w, input int nch);
    return {r[8:0], c[8:0], ch[8:0], co[8:0], r == 0, r == h - 1, c == 0, c == w - 1,
            ch == 0, ch == nch - 1};
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({o_busy, o_done, o_ctrl_csync_run, o_ctrl_data_run} !== 4'b0) begin
      n_err++; $display("FAIL reset_ctrl: got %b required 0000",
                        {o_busy, o_done, o_ctrl_csync_run, o_ctrl_data_run});
    end
    n_vec++;
    if ({o_row, o_col, o_chn, o_chn_out} !== 36'd0) begin
      n_err++; $display("FAIL reset_coord: got %h required 0", {o_row, o_col, o_chn, o_chn_out});
    end
    n_vec++;
    if ({o_is_first_row, o_is_last_row, o_is_first_col, o_is_last_col, o_is_first_chn,
         o_is_last_chn} !== 6'b0) begin
      n_err++; $display("FAIL reset_flags: got %b required 000000",
                        {o_is_first_row, o_is_last_row, o_is_first_col, o_is_last_col,
                         o_is_first_chn, o_is_last_chn});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    logic [41:0] exp_tab[4];
    exp_tab[0] = {9'd0, 9'd0, 9'd0, 9'd0, 6'b101011};
    exp_tab[1] = {9'd0, 9'd1, 9'd0, 9'd0, 6'b100111};
    exp_tab[2] = {9'd1, 9'd0, 9'd0, 9'd0, 6'b011011};
    exp_tab[3] = {9'd1, 9'd1, 9'd0, 9'd0, 6'b010111};
    clear_log(4);
    start_layer(2, 2, 1, 1);
    wait_done(200);
    n_vec++;
    if (pix_n != 4) begin n_err++; $display("FAIL basic_count: got %0d required 4", pix_n); end
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if ({pr[i], pc[i], pch[i], pco[i], pf[i]} !== exp_tab[i]) begin
        n_err++; $display("FAIL basic_pix%0d: got %h required %h", i,
                          {pr[i], pc[i], pch[i], pco[i], pf[i]}, exp_tab[i]);
      end
    end
    n_vec++;
    if (first_sync_cyc - start_cyc != 1) begin
      n_err++; $display("FAIL basic_csync_lat: got %0d required 1", first_sync_cyc - start_cyc);
    end
    n_vec++;
    if (pcyc[0] - start_cyc != 5) begin
      n_err++; $display("FAIL basic_first_pix_lat: got %0d required 5", pcyc[0] - start_cyc);
    end
    n_vec++;
    if (pcyc[3] - pcyc[0] != 3) begin
      n_err++; $display("FAIL basic_rate: got %0d required 3", pcyc[3] - pcyc[0]);
    end
    n_vec++;
    if (done_cyc - pcyc[3] != 16) begin
      n_err++; $display("FAIL basic_done_lat: got %0d required 16", done_cyc - pcyc[3]);
    end
    n_vec++;
    if ({done_n[1:0], busy_at_done, overlap, sync_n[1:0]} !== 6'b01_0_0_01) begin
      n_err++; $display("FAIL basic_misc: got done_n=%0d busy=%b overlap=%b syncs=%0d required 1 0 0 1",
                        done_n, busy_at_done, overlap, sync_n);
    end
  endtask

  task automatic test_multi;
    clear_log(36);
    start_layer(3, 3, 2, 2);
    wait_done(1000);
    n_vec++;
    if (pix_n != 36) begin n_err++; $display("FAIL multi_count: got %0d required 36", pix_n); end
    n_vec++;
    if (sync_n != 4) begin n_err++; $display("FAIL multi_syncs: got %0d required 4", sync_n); end
    for (int k = 0; k < 4; k++) begin
      n_vec++;
      if ({sync_chn[k], sync_cho[k]} !== {9'(k % 2), 9'(k / 2)}) begin
        n_err++; $display("FAIL multi_sync_tile%0d: got (%0d,%0d) required (%0d,%0d)", k,
                          sync_chn[k], sync_cho[k], k % 2, k / 2);
      end
    end
    n_vec++;
    if (sync_cyc[1] - pcyc[8] != 1) begin
      n_err++; $display("FAIL multi_tile_gap: got %0d required 1", sync_cyc[1] - pcyc[8]);
    end
    for (int i = 0; i < 36; i++) begin
      n_vec++;
      if ({pr[i], pc[i], pch[i], pco[i], pf[i]} !==
          exp_pix((i % 9) / 3, i % 3, (i / 9) % 2, i / 18, 3, 3, 2)) begin
        n_err++; $display("FAIL multi_pix%0d: got %h required %h", i,
                          {pr[i], pc[i], pch[i], pco[i], pf[i]},
                          exp_pix((i % 9) / 3, i % 3, (i / 9) % 2, i / 18, 3, 3, 2));
      end
    end
    n_vec++;
    if (overlap !== 1'b0) begin n_err++; $display("FAIL multi_overlap: got 1 required 0"); end
  endtask

  task automatic test_stall;
    clear_log(6);
    rdy_mode = 1;
    start_layer(3, 2, 1, 1);
    wait_done(300);
    rdy_mode = 0;
    n_vec++;
    if (pix_n != 6) begin n_err++; $display("FAIL stall_count: got %0d required 6", pix_n); end
    for (int i = 0; i < 6; i++) begin
      n_vec++;
      if ({pr[i], pc[i], pch[i], pco[i], pf[i]} !== exp_pix(i / 3, i % 3, 0, 0, 2, 3, 1)) begin
        n_err++; $display("FAIL stall_pix%0d: got %h required %h", i,
                          {pr[i], pc[i], pch[i], pco[i], pf[i]}, exp_pix(i / 3, i % 3, 0, 0, 2, 3, 1));
      end
      if (i > 0) begin
        n_vec++;
        if (pcyc[i] - pcyc[i-1] != 2) begin
          n_err++; $display("FAIL stall_spacing%0d: got %0d required 2", i, pcyc[i] - pcyc[i-1]);
        end
      end
    end
`ifdef PE_SCHED_PERF_CNT_EN
    n_vec++;
    if (o_stall_cnt !== 32'(sm_stall)) begin
      n_err++; $display("FAIL stall_cnt: got %0d required %0d", o_stall_cnt, sm_stall);
    end
    n_vec++;
    if (o_cycle_cnt !== 32'(busy_cnt)) begin
      n_err++; $display("FAIL cycle_cnt: got %0d required %0d", o_cycle_cnt, busy_cnt);
    end
`endif
  endtask

  task automatic test_zero;
    clear_log(0);
    start_layer(3, 0, 1, 1);
    wait_done(20);
    n_vec++;
    if (done_cyc - start_cyc != 2) begin
      n_err++; $display("FAIL zero_done_lat: got %0d required 2", done_cyc - start_cyc);
    end
    n_vec++;
    if ({busy_seen, pix_n[5:0], sync_n[3:0]} !== 11'd0) begin
      n_err++; $display("FAIL zero_no_run: got busy=%b pix=%0d syncs=%0d required 0 0 0",
                        busy_seen, pix_n, sync_n);
    end
  endtask

  task automatic test_busy_start;
    clear_log(4);
    start_layer(2, 2, 1, 1);
    @(negedge clk);
    q_width = 9'd3; q_height = 9'd3; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    wait_done(200);
    n_vec++;
    if (pix_n != 4) begin n_err++; $display("FAIL busy_start_count: got %0d required 4", pix_n); end
    repeat (5) @(negedge clk);
    n_vec++;
    if ({o_busy, done_n[3:0]} !== 5'b0_0001) begin
      n_err++; $display("FAIL busy_start_idle: got busy=%b done_n=%0d required 0 1", o_busy, done_n);
    end
  endtask

  task automatic test_reset_mid;
    int k = 0;
    clear_log(9);
    start_layer(3, 3, 1, 1);
    while (pix_n < 3 && k < 100) begin
      @(negedge clk);
      k++;
    end
    n_vec++;
    if (pix_n < 3) begin n_err++; $display("FAIL rstmid_reach_data: got %0d pixels required 3", pix_n); end
    #1 rst = 1'b1;
    #1;
    n_vec++;
    if ({o_busy, o_done, o_ctrl_csync_run, o_ctrl_data_run, o_row, o_col, o_chn, o_chn_out,
         o_is_first_row, o_is_last_row, o_is_first_col, o_is_last_col, o_is_first_chn,
         o_is_last_chn} !== 46'd0) begin
      n_err++; $display("FAIL rstmid_outputs: got busy=%b done=%b cs=%b dr=%b coord=%h required all 0",
                        o_busy, o_done, o_ctrl_csync_run, o_ctrl_data_run,
                        {o_row, o_col, o_chn, o_chn_out});
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if (done_n != 0) begin n_err++; $display("FAIL rstmid_no_done: got %0d required 0", done_n); end
    clear_log(4);
    start_layer(2, 2, 1, 1);
    wait_done(200);
    n_vec++;
    if (pix_n != 4) begin n_err++; $display("FAIL rstmid_fresh_count: got %0d required 4", pix_n); end
    n_vec++;
    if ({pr[3], pc[3], pf[3]} !== {9'd1, 9'd1, 6'b010111}) begin
      n_err++; $display("FAIL rstmid_fresh_last: got %h required %h", {pr[3], pc[3], pf[3]},
                        {9'd1, 9'd1, 6'b010111});
    end
  endtask

  initial begin
    clear_log(0);
    test_reset;
    test_basic;
    test_multi;
    test_stall;
    test_zero;
    test_busy_start;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pe_sched.md
# pe_sched

Tile scheduler that sequences the PE engine through one convolution layer. Per layer it walks output-channel tiles, then input-channel tiles, then rows and columns. For each input-channel tile it first runs a filter-sync phase and waits for the engine's sync-done. It then streams one pixel coordinate per cycle with first/last flags, and drains the PE pipeline before signalling layer done. It sits between the top-level layer controller and the PE engine's `c_*` inputs.

## Interface
- W_SIZE, 9: width of row/col coordinates and of q_width/q_height.
- W_CHANNEL, 9: width of channel-tile indices and of q_channel/q_channel_out.
- DRAIN, 15: cycles waited after the last pixel before done (PE pipeline depth).
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_start  in  1  one-cycle layer start pulse.
- q_width  in  W_SIZE  columns per tile; sampled at accepted start.
- q_height  in  W_SIZE  rows per tile; sampled at accepted start.
- q_channel  in  W_CHANNEL  input-channel tiles; sampled at accepted start.
- q_channel_out  in  W_CHANNEL  output-channel tiles; sampled at accepted start.
- i_ifm_rdy  in  1  IFM buffer can accept a pixel read this cycle.
- i_pe_csync_done  in  1  PE engine filter load complete.
- o_ctrl_csync_run  out  1  filter-sync phase active.
- o_ctrl_data_run  out  1  pixel valid this cycle.
- o_row, o_col  out  W_SIZE  current pixel coordinate.
- o_chn, o_chn_out  out  W_CHANNEL  current input / output channel tile.
- o_is_first_row, o_is_last_row, o_is_first_col, o_is_last_col, o_is_first_chn, o_is_last_chn  out  1 each  position flags for the current coordinate.
- o_busy  out  1  layer in progress.
- o_done  out  1  one-cycle layer-complete pulse.

## Operation
- All outputs are registered. Every output resets to 0 and the state resets to IDLE.
- States:
  - IDLE: on i_start, latch q_* and zero all counters, then go to CSYNC.
  - CSYNC: hold o_ctrl_csync_run=1 until i_pe_csync_done is sampled 1, then go to DATA.
  - DATA: on each cycle with i_ifm_rdy=1, emit the current coordinate and advance. Col is fastest, then row.
  - After the last pixel of a tile (row=q_height-1, col=q_width-1):
    - If not the last tile, advance the tile counters and go to CSYNC.
    - Otherwise go to DRAIN.
  - Tile counter order: chn wraps at q_channel-1, and chn_out increments on that wrap.
  - DRAIN: count DRAIN cycles, then go to DONE.
  - DONE: o_done=1 for one cycle, o_busy=0, then go to IDLE.
- o_busy=1 in every state except IDLE and DONE.
- Flag rules:
  - first_row: row==0. last_row: row==q_height-1.
  - first_col: col==0. last_col: col==q_width-1.
  - first_chn: chn==0. last_chn: chn==q_channel-1.
  - Flags are valid whenever coordinates are driven.
- Coordinates and flags hold their last value when o_ctrl_data_run=0. In CSYNC they show the upcoming tile at (0,0).
- Boundaries:
  - i_start while o_busy=1 is ignored.
  - i_start with any q_* equal to 0: no csync or data runs. o_done pulses 2 cycles after start and o_busy stays 0.
  - q_width=1 or q_height=1: first and last flags are asserted together.
  - i_pe_csync_done outside CSYNC is ignored.
  - rst asserted mid-layer returns to IDLE immediately with all outputs 0. No done pulse.

## Timing
- Start: i_start sampled at cycle 0 gives o_busy=1 and o_ctrl_csync_run=1 at cycle 1.
- CSYNC to DATA:
  - i_pe_csync_done sampled 1 at cycle n gives o_ctrl_csync_run=0 at cycle n+1.
  - The first pixel appears at the cycle after the first sampled i_ifm_rdy=1 at or after n+1.
- Pixel throughput: i_ifm_rdy=1 at cycle t gives a pixel (o_ctrl_data_run=1) at cycle t+1. The peak rate is 1 pixel/cycle.
- Between tiles: last pixel at cycle t gives o_ctrl_csync_run=1 at cycle t+1. o_ctrl_csync_run is therefore low for at least one cycle between syncs, so the engine sees a fresh rising edge.
- End of layer: last pixel of the layer at cycle t gives o_done=1 at cycle t+DRAIN+1.
- o_ctrl_csync_run and o_ctrl_data_run are never high together.

## Configuration
- PE_SCHED_PERF_CNT_EN defined:
  - Adds output o_cycle_cnt (32 bits, cleared at accepted start) counting o_busy cycles.
  - Adds output o_stall_cnt (32 bits) counting DATA cycles with i_ifm_rdy=0.
  - Both hold their value after done and saturate at all-ones.
- Undefined: both ports and their counters are absent. Behaviour is otherwise identical.

## Test plan
- Basic layer: q_width=2, q_height=2, q_channel=1, q_channel_out=1, i_ifm_rdy=1, csync_done 3 cycles after csync_run rises.
  - Exactly 4 data pulses at (0,0),(0,1),(1,0),(1,1) with correct flags.
  - o_done 16 cycles after the last pulse.
- Multiple tiles: q_channel=2, q_channel_out=2, 3x3 tile.
  - 4 csync phases, 36 pixels.
  - (chn,chn_out) order (0,0),(1,0),(0,1),(1,1).
  - last_chn high only for chn=1.
- Stall: toggle i_ifm_rdy every cycle during DATA.
  - Pixels at half rate with no skipped or duplicated coordinates.
  - With PE_SCHED_PERF_CNT_EN, o_stall_cnt equals the number of low i_ifm_rdy cycles in DATA.
- Zero size: start with q_height=0 → no runs, o_done at cycle 2, o_busy never 1.
- Start while busy: second i_start mid-layer → ignored, original pixel count unchanged.
- Reset mid-layer: assert rst during DATA → all outputs 0 the same cycle. A fresh start afterwards runs a complete layer.
